// File: rtl/ucode_store.sv
// Microcode store: asynchronous-read control-word ROM image,
// loaded at boot over a checksummed byte stream.
module ucode_store #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 24,
  parameter logic [DATA_W-1:0] SAFE_WORD = 24'h1BBEEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_decodeAddr,
  output logic [DATA_W-1:0] o_decodeData,
  output logic              o_halt,
  input  logic              i_loadStart,
  input  logic [7:0]        i_loadData,
  input  logic              i_loadValid,
  output logic              o_loadReady,
  output logic              o_loaded,
  output logic              o_loadError
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0] bidx_q, bidx_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [7:0] sum_q, sum_d;
  logic we;
  logic accept;
  logic [16:0] n_new;
  logic rd_hit;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign o_loadReady = (state_q == S_CNT_LO) || (state_q == S_CNT_HI)
                    || (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept = i_loadValid && o_loadReady;
  assign o_loaded = (state_q == S_DONE);
  assign o_loadError = (state_q == S_ERR);
  assign o_halt = ~o_loaded;

  // Unloaded, failed or out-of-image reads return the all-inactive word
  assign rd_hit = o_loaded && (17'(i_decodeAddr) < {1'b0, cnt_q});
  assign o_decodeData = rd_hit ? mem_q[i_decodeAddr] : SAFE_WORD;

  // Next-state: frame parser, start pulse overrides any same-cycle byte
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    bidx_d = bidx_q;
    b0_d = b0_q;
    b1_d = b1_q;
    sum_d = sum_q;
    we = 1'b0;
    n_new = {1'b0, i_loadData, cnt_q[7:0]};
    if (i_loadStart) begin
      state_d = S_CNT_LO;
      cnt_d = '0;
      ptr_d = '0;
      bidx_d = '0;
      sum_d = '0;
    end else if (accept) begin
      case (state_q)
        S_CNT_LO: begin
          cnt_d[7:0] = i_loadData;
          state_d = S_CNT_HI;
        end
        S_CNT_HI: begin
          cnt_d[15:8] = i_loadData;
          if (n_new > DEPTH_W) state_d = S_ERR;
          else if (n_new == '0) state_d = S_CHECK;
          else state_d = S_DATA;
        end
        S_DATA: begin
          sum_d = sum_q + i_loadData;
          case (bidx_q)
            2'd0: begin
              b0_d = i_loadData;
              bidx_d = 2'd1;
            end
            2'd1: begin
              b1_d = i_loadData;
              bidx_d = 2'd2;
            end
            default: begin
              we = 1'b1;
              bidx_d = 2'd0;
              ptr_d = ptr_q + ADDR_W'(1);
              if (17'(ptr_q) + 17'd1 == {1'b0, cnt_q})
                state_d = S_CHECK;
            end
          endcase
        end
        S_CHECK: begin
          state_d = (i_loadData == sum_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      bidx_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      bidx_q <= bidx_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      sum_q <= sum_d;
    end
  end

  // Word write on the third byte; array contents survive reset
  always_ff @(posedge i_clk) begin
    if (we) mem_q[ptr_q] <= {i_loadData, b1_q, b0_q};
  end

endmodule

// File: tb/tb_ucode_store.sv
// Bench for ucode_store: directed boot frames plus random frames
// checked against a frame-level model of the store.
module tb_ucode_store;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [23:0] SAFE = 24'h1BBEEF;

  logic i_clk;
  logic i_reset;
  logic [AW-1:0] i_decodeAddr;
  logic [23:0] o_decodeData;
  logic o_halt;
  logic i_loadStart;
  logic [7:0] i_loadData;
  logic i_loadValid;
  logic o_loadReady;
  logic o_loaded;
  logic o_loadError;

  ucode_store #(.ADDR_W(AW)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_decodeAddr(i_decodeAddr),
    .o_decodeData(o_decodeData),
    .o_halt(o_halt),
    .i_loadStart(i_loadStart),
    .i_loadData(i_loadData),
    .i_loadValid(i_loadValid),
    .o_loadReady(o_loadReady),
    .o_loaded(o_loaded),
    .o_loadError(o_loadError)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk;
  int n_pass;

  logic [23:0] m_mem [DEPTH];
  int m_n;
  bit m_loaded;
  bit m_err;

  logic [23:0] fw [32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  function automatic int gap_of(input int g);
    if (g < 0) return -g;
    if (g == 0) return 0;
    return $urandom_range(0, g);
  endfunction

  task automatic put_byte(input logic [7:0] b, input int gap);
    bit ok;
    bit acc;
    acc = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_loadData = b;
    i_loadValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ok = o_loadReady;
      @(negedge i_clk);
      if (ok) begin
        acc = 1'b1;
        break;
      end
    end
    i_loadValid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    i_loadStart = 1'b1;
    @(negedge i_clk);
    i_loadStart = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit corrupt,
                            input int gap, input bit do_start);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    if (do_start) pulse_start();
    put_byte(n[7:0], gap_of(gap));
    put_byte(n[15:8], gap_of(gap));
    if (n > DEPTH) begin
      m_loaded = 1'b0;
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 3; j++) begin
        b = fw[i][8*j +: 8];
        s = s + b;
        put_byte(b, gap_of(gap));
      end
    end
    if (corrupt) b = s + 8'($urandom_range(1, 255));
    else b = s;
    put_byte(b, gap_of(gap));
    if (corrupt) begin
      m_loaded = 1'b0;
      m_err = 1'b1;
    end else begin
      m_loaded = 1'b1;
      m_err = 1'b0;
      m_n = n;
      for (int i = 0; i < n; i++) m_mem[i] = fw[i];
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] exp;
    chk({tag, ".loaded"}, 32'(o_loaded), 32'(m_loaded));
    chk({tag, ".err"}, 32'(o_loadError), 32'(m_err));
    chk({tag, ".halt"}, 32'(o_halt), 32'(!m_loaded));
    chk({tag, ".ready"}, 32'(o_loadReady), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      i_decodeAddr = AW'(a);
      #1;
      exp = (m_loaded && a < m_n) ? m_mem[a] : SAFE;
      chk($sformatf("%s.rd%0d", tag, a), 32'(o_decodeData), 32'(exp));
      @(negedge i_clk);
    end
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_pass = 0;
    m_n = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    i_reset = 1'b1;
    i_loadStart = 1'b0;
    i_loadData = 8'h00;
    i_loadValid = 1'b0;
    i_decodeAddr = '0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    check_all("reset");

    fw[0] = 24'h123456;
    fw[1] = 24'h00ABCD;
    send_frame(2, 1'b0, 0, 1'b1);
    check_all("good");

    send_frame(2, 1'b1, 0, 1'b1);
    check_all("badsum");

    send_frame(17, 1'b0, 0, 1'b1);
    check_all("ovf");

    send_frame(2, 1'b0, -3, 1'b1);
    check_all("stall");

    pulse_start();
    put_byte(8'h02, 0);
    put_byte(8'h00, 0);
    put_byte(8'h11, 0);
    put_byte(8'h22, 0);
    i_loadStart = 1'b1;
    i_loadValid = 1'b1;
    i_loadData = 8'hFF;
    @(negedge i_clk);
    i_loadStart = 1'b0;
    i_loadValid = 1'b0;
    fw[0] = 24'hC0FFEE;
    fw[1] = 24'h0A0B0C;
    send_frame(2, 1'b0, 0, 1'b0);
    check_all("restart");

    pulse_start();
    put_byte(8'h02, 0);
    put_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) put_byte(8'(i + 1), 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    check_all("rstmid");

    send_frame(0, 1'b0, 0, 1'b1);
    check_all("zero");

    for (int i = 0; i < DEPTH; i++) fw[i] = 24'($urandom);
    send_frame(DEPTH, 1'b0, 1, 1'b1);
    check_all("full");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) n = $urandom_range(DEPTH + 1, DEPTH + 4);
      else n = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) fw[i] = 24'($urandom);
      send_frame(n, $urandom_range(0, 3) == 0, 2, 1'b1);
      check_all($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ucode_store.md
Name: ucode_store

Overview:
- Microcode store on the responder side of the control sequencer's decode interface.
- Takes the decode address {flags[3:0], instr[7:0], step[2:0]} and returns the 24-bit microcode control word with zero latency, behaving like an asynchronous EEPROM.
- Contents are loaded at boot over a byte-wide valid/ready stream.
- Holds the sequencer halted and drives an all-inactive control word until a checksummed load completes.

Parameters:
- ADDR_W, 15, decode address width; store depth is 2^ADDR_W words.
- DATA_W, 24, microcode word width (fixed framing of 3 bytes/word; only 24 supported).
- SAFE_WORD, 24'h1BBEEF, control word with every control inactive (active-low enables high, selects low, InstrFinishedN high).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_decodeAddr  in  ADDR_W  address from the sequencer.
- o_decodeData  out  DATA_W  microcode word; combinational from i_decodeAddr and state.
- o_halt  out  1  high until a successful load; feeds the sequencer halt input.
- i_loadStart  in  1  single-cycle pulse that begins or restarts a load.
- i_loadData  in  8  load stream byte.
- i_loadValid  in  1  byte present.
- o_loadReady  out  1  byte accepted at a rising edge when i_loadValid and o_loadReady are both high.
- o_loaded  out  1  store holds a verified image.
- o_loadError  out  1  last load failed; sticky until the next i_loadStart or reset.

Behaviour:
- Reset:
  - state=IDLE, o_loaded=0, o_loadError=0, o_loadReady=0, o_halt=1.
  - Internal pointer, word count and checksum are cleared.
  - The memory array is NOT cleared.
- Frame format: count_lo, count_hi (N, 16-bit little-endian), then N words of 3 bytes each (b0 LSB, b1, b2 MSB), then 1 checksum byte.
  - The checksum is the 8-bit sum (mod 256) of the data bytes only; count bytes are excluded.
- States: IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR.
  - IDLE/DONE/ERR: o_loadReady=0. i_loadStart goes to CNT_LO and clears o_loaded, o_loadError, the pointer and the checksum.
  - CNT_LO: o_loadReady=1. On accept, latch the low byte and go to CNT_HI.
  - CNT_HI: on accept, latch the high byte.
    - If N > 2^ADDR_W, go to ERR.
    - Else if N==0, go to CHECK.
    - Else go to DATA.
  - DATA: accept bytes and add each to the checksum.
    - On the third byte of a word, write {b2,b1,b0} to mem[ptr] in the accept cycle, then increment ptr.
    - After word N-1 is written, go to CHECK.
  - CHECK: on accept, go to DONE (o_loaded=1) if the byte equals the checksum, else go to ERR (o_loadError=1).
- i_loadStart in any non-IDLE state restarts at CNT_LO with pointer/checksum cleared. It has priority over a byte accepted in the same cycle, which is discarded.
- o_halt = ~o_loaded at all times; the sequencer freezes during load and after an error.
- Read path:
  - o_decodeData = mem[i_decodeAddr] when o_loaded && i_decodeAddr < N.
  - Otherwise o_decodeData = SAFE_WORD, including during load, after error, and for addresses at or beyond N.
  - Read is same-cycle combinational, with no registers in the path.
- Gaps in i_loadValid are allowed anywhere; state is held while i_loadValid=0.
- Reset mid-load aborts the load: o_loaded=0, and partially written memory is unreadable because of the o_loaded gating.
- N = 2^ADDR_W fills the store; the pointer never wraps during a legal load.

Test Plan:
- Reset and idle: after reset -> o_halt=1, o_loaded=0, o_loadReady=0, o_decodeData=0x1BBEEF for any address.
- Good load, back-to-back bytes: start; send 02 00 56 34 12 CD AB 00 14 -> o_loaded=1, o_halt=0, o_loadError=0.
  - Addr 0 reads 0x123456, addr 1 reads 0x00ABCD, addr 2 reads 0x1BBEEF (same-cycle response to an address change).
- Bad checksum: same frame with last byte 0x15 -> o_loadError=1, o_halt=1, o_loaded=0, addr 0 reads 0x1BBEEF.
- Count overflow (ADDR_W=4): send count 11 00 -> ERR immediately after count_hi, o_loadReady=0, o_loadError=1.
- Stall and restart: good frame with i_loadValid dropped for 3 cycles between bytes -> identical result.
  - i_loadStart pulsed mid-DATA, then a full good frame -> loads correctly, error clear.
- Reset mid-load, then zero-length frame: reset after 4 data bytes -> o_loaded=0, o_halt=1.
  - Then frame 00 00 00 -> o_loaded=1 and every address reads 0x1BBEEF.
